alarm_controller: RTL
=====================

# alarm_controller

Sequencing controller for the alarm clock display and alarm path. It holds the alarm time, runs the button-driven alarm-set state machine, detects the alarm match against the running time, and handles the ringing/snooze timing. It also selects the BCD fields fed to `seven_segment`: running time normally, alarm time while setting. It sits between the timekeeper counter and `seven_segment`.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per 1 s tick (≥2, even).
- `SNOOZE_MIN`, 5: snooze length in minutes (1..15).
- `RING_SEC`, 60: auto-stop ringing after this many seconds (1..255).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `H_MSB`  in  2  running time hour tens (BCD, 0..2).
- `H_LSB, M_MSB, M_LSB, S_MSB, S_LSB`  in  4 each  running time BCD digits.
- `alarm_en`  in  1  level; alarm armed.
- `btn_set, btn_inc, btn_snooze, btn_off`  in  1 each  single-cycle debounced pulses.
- `disp_H_MSB`  out  2  hour tens to `seven_segment`.
- `disp_H_LSB, disp_M_MSB, disp_M_LSB, disp_S_MSB, disp_S_LSB`  out  4 each  digits to `seven_segment`.
- `set_led`  out  2  01 = setting hours, 10 = setting minutes, 00 otherwise.
- `ringing`  out  1  high in RINGING.
- `snoozing`  out  1  high in SNOOZE.
- `buzzer`  out  1  gated 1 Hz tone enable.

## Operation
- States: NORMAL, SET_HR, SET_MIN, RINGING, SNOOZE. Reset state is NORMAL.
- Alarm register (AH 00..23, AM 00..59, BCD). Reset value is 07:00.
- Tick counter: 0..TICK_DIV-1, wraps. `tick` pulses for one cycle when the count is TICK_DIV-1. It runs in all states.
- `match` = `alarm_en` & (time HH:MM == alarm HH:MM) & S == 00. It is registered each cycle. `trigger` = `match` & ~`match_d` (rising edge only), so the alarm cannot re-fire within the same second.
- NORMAL:
  - `btn_set` → SET_HR.
  - else `trigger` → RINGING, with ring_cnt loaded to RING_SEC.
  - Display shows running time.
- SET_HR:
  - Display shows alarm HH:MM:00. `set_led` = 01.
  - `btn_inc`: AH+1, 23 wraps to 00 (tens/units carry in BCD).
  - `btn_set` → SET_MIN.
- SET_MIN:
  - `set_led` = 10.
  - `btn_inc`: AM+1, 59 wraps to 00. No carry into hours.
  - `btn_set` → NORMAL.
- Triggers are ignored in both SET states. `btn_set` and `btn_inc` in the same cycle: the transition wins and there is no increment.
- RINGING (transition priority, highest first):
  - `btn_off` or ~`alarm_en` → NORMAL.
  - `btn_snooze` → SNOOZE, with snz_cnt loaded to SNOOZE_MIN*60.
  - `tick` with ring_cnt == 1 → NORMAL.
  - otherwise `tick` decrements ring_cnt.
  - `buzzer` = 1 while the tick counter < TICK_DIV/2, else 0.
  - Display shows running time.
- SNOOZE (priority, highest first):
  - `btn_off` or ~`alarm_en` → NORMAL.
  - `tick` with snz_cnt == 1 → RINGING, with ring_cnt reloaded to RING_SEC.
  - otherwise `tick` decrements snz_cnt.
  - `btn_set` is ignored. `buzzer` = 0.
- Counter widths: ring_cnt is 8 bits, snz_cnt is 10 bits (max 900). There is no underflow: counters are only decremented when > 1.

## Timing
- All outputs are registered. Display, `set_led`, `ringing`, `snoozing` and `buzzer` reflect the state and inputs of the previous edge, i.e. 1-cycle latency.
- Reset values: all disp_* = 0, `set_led` = 00, `ringing` = 0, `snoozing` = 0, `buzzer` = 0. Tick counter = 0, ring_cnt = 0, snz_cnt = 0, `match_d` = 0.
- Reset mid-RINGING or mid-SNOOZE: the next cycle is NORMAL with outputs at reset values. The alarm register returns to 07:00.
- Ring and snooze durations are counted in whole ticks. The first decrement occurs on the first tick after entry, so the duration is between N-1 and N seconds.
- A button pulse in a state that does not consume it has no effect.

## Test plan
- Reset with time 12:34:56 applied → cycle after reset release: disp = 12:34:56, `set_led` = 00, `buzzer` = 0.
- `btn_set`, then 17× `btn_inc` → disp_H = 00 (07+17 wraps through 23). `btn_set`, then 61× `btn_inc` → disp_M = 01. `btn_set` → NORMAL, disp = running time.
- TICK_DIV=4, RING_SEC=5, alarm 00:01, `alarm_en`=1, time steps to 00:01:00 → `ringing` 1 cycle later. `buzzer` toggles 2 high / 2 low cycles. `ringing` drops after 5 ticks with no input. Holding 00:01:00 afterwards does not re-trigger.
- Ringing, pulse `btn_snooze` with SNOOZE_MIN=1, TICK_DIV=4 → `snoozing`=1, `buzzer`=0. After 60 ticks `ringing`=1 and ring_cnt = RING_SEC.
- Ringing, `btn_off` and `btn_snooze` in the same cycle → NORMAL, `snoozing` stays 0. Setting `alarm_en`=0 during SNOOZE → NORMAL.
- `rst` pulsed mid-SNOOZE → all outputs at reset values next cycle. Alarm register reads back 07:00 in SET_HR.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm clock sequencer: alarm register, button-driven set FSM, alarm match,
// ring/snooze timing and display field selection for seven_segment.
module alarm_controller #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] H_MSB,
  input  logic [3:0] H_LSB,
  input  logic [3:0] M_MSB,
  input  logic [3:0] M_LSB,
  input  logic [3:0] S_MSB,
  input  logic [3:0] S_LSB,
  input  logic       alarm_en,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       btn_off,
  output logic [1:0] disp_H_MSB,
  output logic [3:0] disp_H_LSB,
  output logic [3:0] disp_M_MSB,
  output logic [3:0] disp_M_LSB,
  output logic [3:0] disp_S_MSB,
  output logic [3:0] disp_S_LSB,
  output logic [1:0] set_led,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int unsigned TickW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(TICK_DIV / 2);
  localparam logic [7:0] RingLoad  = 8'(RING_SEC);
  localparam logic [9:0] SnzLoad   = 10'(SNOOZE_MIN * 60);

  typedef enum logic [2:0] {StNormal, StSetHr, StSetMin, StRinging, StSnooze} state_e;

  state_e           state_q, state_d;
  logic [5:0]       ah_q, ah_d;    // {tens[1:0], units[3:0]}
  logic [6:0]       am_q, am_d;    // {tens[2:0], units[3:0]}
  logic [TickW-1:0] tick_cnt_q;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic [9:0]       snz_cnt_q, snz_cnt_d;
  logic             match_q;
  logic             tick, match, trigger;
  logic [5:0]       ah_inc;
  logic [6:0]       am_inc;

  logic [1:0] h_msb_d, led_d;
  logic [3:0] h_lsb_d, m_msb_d, m_lsb_d, s_msb_d, s_lsb_d;
  logic       ringing_d, snoozing_d, buzzer_d;

  assign tick  = (tick_cnt_q == TickLast);
  assign match = alarm_en && (H_MSB == ah_q[5:4]) && (H_LSB == ah_q[3:0]) &&
                 (M_MSB == {1'b0, am_q[6:4]}) && (M_LSB == am_q[3:0]) &&
                 (S_MSB == 4'd0) && (S_LSB == 4'd0);
  // Rising edge only, so a held match fires once.
  assign trigger = match && !match_q;

  always_comb begin
    if (ah_q == 6'h23)          ah_inc = 6'h00;
    else if (ah_q[3:0] == 4'd9) ah_inc = {ah_q[5:4] + 2'd1, 4'd0};
    else                        ah_inc = {ah_q[5:4], ah_q[3:0] + 4'd1};
    if (am_q == 7'h59)          am_inc = 7'h00;
    else if (am_q[3:0] == 4'd9) am_inc = {am_q[6:4] + 3'd1, 4'd0};
    else                        am_inc = {am_q[6:4], am_q[3:0] + 4'd1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StNormal;
      ah_q       <= 6'h07;
      am_q       <= 7'h00;
      tick_cnt_q <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      match_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ah_q       <= ah_d;
      am_q       <= am_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      match_q    <= match;
    end
  end

  always_comb begin
    state_d    = state_q;
    ah_d       = ah_q;
    am_d       = am_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    unique case (state_q)
      StNormal: begin
        if (btn_set) begin
          state_d = StSetHr;
        end else if (trigger) begin
          state_d    = StRinging;
          ring_cnt_d = RingLoad;
        end
      end
      StSetHr: begin
        if (btn_set)      state_d = StSetMin;
        else if (btn_inc) ah_d = ah_inc;
      end
      StSetMin: begin
        if (btn_set)      state_d = StNormal;
        else if (btn_inc) am_d = am_inc;
      end
      StRinging: begin
        if (btn_off || !alarm_en) begin
          state_d = StNormal;
        end else if (btn_snooze) begin
          state_d   = StSnooze;
          snz_cnt_d = SnzLoad;
        end else if (tick) begin
          if (ring_cnt_q == 8'd1) state_d = StNormal;
          else                    ring_cnt_d = ring_cnt_q - 8'd1;
        end
      end
      StSnooze: begin
        if (btn_off || !alarm_en) begin
          state_d = StNormal;
        end else if (tick) begin
          if (snz_cnt_q == 10'd1) begin
            state_d    = StRinging;
            ring_cnt_d = RingLoad;
          end else begin
            snz_cnt_d = snz_cnt_q - 10'd1;
          end
        end
      end
      default: state_d = StNormal;
    endcase
  end

  always_comb begin
    h_msb_d    = H_MSB;
    h_lsb_d    = H_LSB;
    m_msb_d    = M_MSB;
    m_lsb_d    = M_LSB;
    s_msb_d    = S_MSB;
    s_lsb_d    = S_LSB;
    led_d      = 2'b00;
    ringing_d  = 1'b0;
    snoozing_d = 1'b0;
    buzzer_d   = 1'b0;
    if (state_q == StSetHr || state_q == StSetMin) begin
      h_msb_d = ah_q[5:4];
      h_lsb_d = ah_q[3:0];
      m_msb_d = {1'b0, am_q[6:4]};
      m_lsb_d = am_q[3:0];
      s_msb_d = 4'd0;
      s_lsb_d = 4'd0;
      led_d   = (state_q == StSetHr) ? 2'b01 : 2'b10;
    end
    if (state_q == StRinging) begin
      ringing_d = 1'b1;
      buzzer_d  = (tick_cnt_q < TickHalf);
    end
    if (state_q == StSnooze) snoozing_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_H_MSB <= '0;
      disp_H_LSB <= '0;
      disp_M_MSB <= '0;
      disp_M_LSB <= '0;
      disp_S_MSB <= '0;
      disp_S_LSB <= '0;
      set_led    <= '0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      disp_H_MSB <= h_msb_d;
      disp_H_LSB <= h_lsb_d;
      disp_M_MSB <= m_msb_d;
      disp_M_LSB <= m_lsb_d;
      disp_S_MSB <= s_msb_d;
      disp_S_LSB <= s_lsb_d;
      set_led    <= led_d;
      ringing    <= ringing_d;
      snoozing   <= snoozing_d;
      buzzer     <= buzzer_d;
    end
  end

endmodule
